// File: rtl/ddr3_user_port_arbiter.sv
// Round-robin arbiter that lets two client ports share one ddr3_memory_controller
// user interface and routes read data back to whichever port issued the read.
module ddr3_user_port_arbiter #(
  parameter int ADDR_BITWIDTH    = 18,
  parameter int DQ_BITWIDTH      = 16,
  parameter int STATE_BITWIDTH   = 5,
  parameter int STATE_WRITE_DATA = 8,
  parameter int STATE_READ_DATA  = 11,
  parameter int READ_LATENCY     = 4,
  parameter int ACCEPT_TIMEOUT   = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_req,
  input  logic                      p1_req,
  input  logic                      p0_we,
  input  logic                      p1_we,
  input  logic [ADDR_BITWIDTH-1:0]  p0_addr,
  input  logic [ADDR_BITWIDTH-1:0]  p1_addr,
  input  logic [DQ_BITWIDTH-1:0]    p0_wdata,
  input  logic [DQ_BITWIDTH-1:0]    p1_wdata,
  output logic                      p0_ack,
  output logic                      p1_ack,
  output logic                      p0_rvalid,
  output logic                      p1_rvalid,
  output logic [DQ_BITWIDTH-1:0]    rdata,
  input  logic [STATE_BITWIDTH-1:0] ctrl_main_state,
  output logic                      ctrl_write_enable,
  output logic                      ctrl_read_enable,
  output logic [ADDR_BITWIDTH-1:0]  ctrl_address,
  output logic [DQ_BITWIDTH-1:0]    ctrl_data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]    ctrl_data_from_ram,
  output logic                      busy,
  output logic                      timeout_error
);

  localparam int CNT_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [STATE_BITWIDTH-1:0] ST_WR = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] ST_RD = STATE_BITWIDTH'(STATE_READ_DATA);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     rr_q, rr_d;
  logic                     lwe_q, lwe_d;
  logic                     wen_q, wen_d;
  logic                     ren_q, ren_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [DQ_BITWIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     to_q, to_d;

  logic                     accept;
  logic                     timeout_hit;
  logic                     win;
  logic                     push_rd;
  logic [READ_LATENCY-1:0]  rd_vld_q;
  logic [READ_LATENCY-1:0]  rd_tag_q;
  logic [DQ_BITWIDTH-1:0]   rdata_q;
  logic                     rv0_q, rv1_q;

  assign accept      = (state_q == S_GRANT) &&
                       (lwe_q ? (ctrl_main_state == ST_WR) : (ctrl_main_state == ST_RD));
  assign timeout_hit = (state_q == S_GRANT) && !accept &&
                       (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1));
  // A lone requester always wins; contention goes to the round-robin favourite.
  assign win         = (p0_req && p1_req) ? rr_q : p1_req;
  assign push_rd     = accept && !lwe_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    lwe_d   = lwe_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          owner_d = win;
          lwe_d   = win ? p1_we : p0_we;
          addr_d  = win ? p1_addr : p0_addr;
          wdata_d = win ? p1_wdata : p0_wdata;
          wen_d   = win ? p1_we : p0_we;
          ren_d   = win ? !p1_we : !p0_we;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (accept) begin
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          ack0_d  = !owner_q;
          ack1_d  = owner_q;
          rr_d    = !owner_q;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          // The client keeps requesting, so it simply re-enters arbitration.
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          to_d    = 1'b1;
          rr_d    = !owner_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      lwe_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lwe_q   <= lwe_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      to_q    <= to_d;
    end
  end

  // Read-return pipeline: valid bits are flushed by reset, owner tags need not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q <= '0;
      rdata_q  <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      rd_vld_q[0] <= push_rd;
      for (int i = 1; i < READ_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      if (rd_vld_q[READ_LATENCY-1]) rdata_q <= ctrl_data_from_ram;
      rv0_q <= rd_vld_q[READ_LATENCY-1] && !rd_tag_q[READ_LATENCY-1];
      rv1_q <= rd_vld_q[READ_LATENCY-1] &&  rd_tag_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_tag_q[0] <= owner_q;
    for (int i = 1; i < READ_LATENCY; i++) rd_tag_q[i] <= rd_tag_q[i-1];
  end

  assign p0_ack            = ack0_q;
  assign p1_ack            = ack1_q;
  assign p0_rvalid         = rv0_q;
  assign p1_rvalid         = rv1_q;
  assign rdata             = rdata_q;
  assign ctrl_write_enable = wen_q;
  assign ctrl_read_enable  = ren_q;
  assign ctrl_address      = addr_q;
  assign ctrl_data_to_ram  = wdata_q;
  assign busy              = (state_q == S_GRANT);
  assign timeout_error     = to_q;

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// Bench for ddr3_user_port_arbiter: a transaction-level model predicts every output
// each cycle; directed scenarios add literal expectations, then random traffic runs.
module tb_ddr3_user_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SW = 5;
  localparam int L  = 4;
  localparam int TO = 7;
  localparam int MI = 0, MG = 1, MD = 2;

  logic clk = 1'b0;
  logic reset;
  logic p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DW-1:0] rdata;
  logic [SW-1:0] ctrl_main_state;
  logic ctrl_write_enable, ctrl_read_enable;
  logic [AW-1:0] ctrl_address;
  logic [DW-1:0] ctrl_data_to_ram, ctrl_data_from_ram;
  logic busy, timeout_error;

  ddr3_user_port_arbiter #(
    .ADDR_BITWIDTH(AW), .DQ_BITWIDTH(DW), .STATE_BITWIDTH(SW),
    .STATE_WRITE_DATA(8), .STATE_READ_DATA(11),
    .READ_LATENCY(L), .ACCEPT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .ctrl_main_state(ctrl_main_state),
    .ctrl_write_enable(ctrl_write_enable), .ctrl_read_enable(ctrl_read_enable),
    .ctrl_address(ctrl_address), .ctrl_data_to_ram(ctrl_data_to_ram),
    .ctrl_data_from_ram(ctrl_data_from_ram), .busy(busy), .timeout_error(timeout_error)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state and predicted outputs
  int m_state, m_cnt, cyc;
  bit m_owner, m_rr, m_lwe;
  bit e_we, e_re, e_busy, e_ack0, e_ack1, e_rv0, e_rv1, e_to;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  typedef struct { int due; bit port; } rd_t;
  rd_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MI; m_cnt = 0; m_owner = 0; m_rr = 0; m_lwe = 0;
    e_we = 0; e_re = 0; e_busy = 0; e_ack0 = 0; e_ack1 = 0;
    e_rv0 = 0; e_rv1 = 0; e_to = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    rq.delete();
  endtask

  task automatic model_step();
    bit acc;
    cyc++;
    if (reset) begin model_reset(); return; end
    e_ack0 = 0; e_ack1 = 0; e_rv0 = 0; e_rv1 = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rdata = ctrl_data_from_ram;
      if (rq[0].port) e_rv1 = 1; else e_rv0 = 1;
      void'(rq.pop_front());
    end
    case (m_state)
      MI: if (p0_req || p1_req) begin
        m_owner = (p0_req && p1_req) ? m_rr : p1_req;
        m_lwe   = m_owner ? p1_we : p0_we;
        e_addr  = m_owner ? p1_addr : p0_addr;
        e_wdata = m_owner ? p1_wdata : p0_wdata;
        e_we = m_lwe; e_re = !m_lwe; e_busy = 1; m_cnt = 0; m_state = MG;
      end
      MG: begin
        m_cnt++;
        acc = m_lwe ? (ctrl_main_state == 8) : (ctrl_main_state == 11);
        if (acc || m_cnt == TO) begin
          e_we = 0; e_re = 0; e_busy = 0; m_rr = !m_owner; m_state = MD;
          if (acc) begin
            if (m_owner) e_ack1 = 1; else e_ack0 = 1;
            if (!m_lwe) rq.push_back('{due: cyc + L, port: m_owner});
          end else e_to = 1;
        end
      end
      default: m_state = MI;
    endcase
  endtask

  task automatic compare_all();
    chk("ctrl_write_enable", 32'(ctrl_write_enable), 32'(e_we));
    chk("ctrl_read_enable", 32'(ctrl_read_enable), 32'(e_re));
    chk("ctrl_address", 32'(ctrl_address), 32'(e_addr));
    chk("ctrl_data_to_ram", 32'(ctrl_data_to_ram), 32'(e_wdata));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("p0_ack", 32'(p0_ack), 32'(e_ack0));
    chk("p1_ack", 32'(p1_ack), 32'(e_ack1));
    chk("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("timeout_error", 32'(timeout_error), 32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic client(input bit ack, inout logic req, inout logic we,
                        inout logic [AW-1:0] addr, inout logic [DW-1:0] wd);
    if (req && ack) req = 0;
    else if (!req && $urandom_range(0, 3) == 0) begin
      req = 1; we = 1'($urandom); addr = AW'($urandom); wd = DW'($urandom);
    end else if (req && $urandom_range(0, 7) == 0) begin
      we = 1'($urandom); addr = AW'($urandom); wd = DW'($urandom);
    end
  endtask

  int ackseq[$];
  int evp[$];
  logic [DW-1:0] evd[$];
  int first_ack;
  int stuck;
  bit done;

  initial begin
    reset = 1; p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    ctrl_main_state = '0; ctrl_data_from_ram = '0; cyc = 0; stuck = 0;
    model_reset();
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(ctrl_write_enable), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 0;
    tick();

    // Both ports request writes continuously: grants must alternate starting at port 0.
    p0_req = 1; p0_we = 1; p0_addr = 18'h1; p0_wdata = 16'h1;
    p1_req = 1; p1_we = 1; p1_addr = 18'h2; p1_wdata = 16'h2;
    ctrl_main_state = 5'd8;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (p0_ack) ackseq.push_back(0);
      if (p1_ack) ackseq.push_back(1);
    end
    chk("alt_ack_count", 32'(ackseq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < ackseq.size(); i++) chk($sformatf("alt_ack_%0d", i), 32'(ackseq[i]), 32'(i % 2));
    p0_req = 0; p1_req = 0;
    for (int i = 0; i < 4; i++) tick();

    // Single write, accepted on the second GRANT cycle.
    ctrl_main_state = 5'd0;
    p0_req = 1; p0_we = 1; p0_addr = 18'h00010; p0_wdata = 16'h1234;
    tick();
    chk("wr_we", 32'(ctrl_write_enable), 32'd1);
    chk("wr_addr", 32'(ctrl_address), 32'h10);
    chk("wr_data", 32'(ctrl_data_to_ram), 32'h1234);
    chk("wr_busy", 32'(busy), 32'd1);
    p0_addr = 18'h2AAAA;
    tick();
    chk("wr_we_hold", 32'(ctrl_write_enable), 32'd1);
    chk("wr_addr_hold", 32'(ctrl_address), 32'h10);
    ctrl_main_state = 5'd8;
    tick();
    chk("wr_ack", 32'(p0_ack), 32'd1);
    chk("wr_we_off", 32'(ctrl_write_enable), 32'd0);
    p0_req = 0; ctrl_main_state = 5'd0;
    tick();
    chk("wr_ack_pulse", 32'(p0_ack), 32'd0);
    tick();

    // p1 read with fixed-latency return.
    p1_req = 1; p1_we = 0; p1_addr = 18'h3FFFF; ctrl_main_state = 5'd11;
    tick();
    chk("rd_re", 32'(ctrl_read_enable), 32'd1);
    chk("rd_addr", 32'(ctrl_address), 32'h3FFFF);
    tick();
    chk("rd_ack", 32'(p1_ack), 32'd1);
    p1_req = 0; ctrl_main_state = 5'd0;
    for (int i = 0; i < 3; i++) begin
      ctrl_data_from_ram = DW'($urandom_range(0, 16'hBEEE));
      tick();
      chk("rd_no_early_rvalid", 32'(p1_rvalid), 32'd0);
    end
    ctrl_data_from_ram = 16'hBEEF;
    tick();
    chk("rd_rvalid", 32'(p1_rvalid), 32'd1);
    chk("rd_rdata", 32'(rdata), 32'hBEEF);
    chk("rd_p0_quiet", 32'(p0_rvalid), 32'd0);
    ctrl_data_from_ram = 16'h0;
    tick();
    chk("rd_rvalid_pulse", 32'(p1_rvalid), 32'd0);
    chk("rd_rdata_hold", 32'(rdata), 32'hBEEF);

    // Back-to-back reads p0 then p1: returns keep order and owner.
    p0_req = 1; p0_we = 0; p0_addr = 18'h5; p1_req = 1; p1_we = 0; p1_addr = 18'h6;
    ctrl_main_state = 5'd11; ctrl_data_from_ram = 16'h0001;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (e_ack0) p0_req = 0;
      if (e_ack1) p1_req = 0;
      if (p0_rvalid) begin evp.push_back(0); evd.push_back(rdata); end
      if (p1_rvalid) begin evp.push_back(1); evd.push_back(rdata); end
      if (evp.size() >= 1) ctrl_data_from_ram = 16'h0002;
      if (evp.size() >= 2) done = 1;
    end
    chk("b2b_returns", 32'(evp.size()), 32'd2);
    if (evp.size() >= 2) begin
      chk("b2b_first_port", 32'(evp[0]), 32'd0);
      chk("b2b_first_data", 32'(evd[0]), 32'h0001);
      chk("b2b_second_port", 32'(evp[1]), 32'd1);
      chk("b2b_second_data", 32'(evd[1]), 32'h0002);
    end
    p0_req = 0; p1_req = 0; ctrl_main_state = 5'd0;
    for (int i = 0; i < 4; i++) tick();

    // Acceptance timeout on a p0 write, with p1 waiting behind it.
    p0_req = 1; p0_we = 1; p0_addr = 18'h77;
    tick();
    p1_req = 1; p1_we = 1; p1_addr = 18'h88;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_busy_before", 32'(busy), 32'd1);
    chk("to_flag_before", 32'(timeout_error), 32'd0);
    tick();
    chk("to_flag", 32'(timeout_error), 32'd1);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_no_ack", 32'(p0_ack), 32'd0);
    chk("to_we_off", 32'(ctrl_write_enable), 32'd0);
    ctrl_main_state = 5'd8;
    first_ack = -1;
    for (int i = 0; i < 10 && first_ack < 0; i++) begin
      tick();
      if (p0_ack) first_ack = 0;
      else if (p1_ack) first_ack = 1;
    end
    chk("to_next_grant_p1", 32'(first_ack), 32'd1);
    p1_req = 0;
    first_ack = -1;
    for (int i = 0; i < 10 && first_ack < 0; i++) begin
      tick();
      if (p0_ack) first_ack = 0;
    end
    chk("to_p0_retried", 32'(first_ack), 32'd0);
    p0_req = 0;
    tick();
    chk("to_sticky", 32'(timeout_error), 32'd1);
    #2 reset = 1; model_reset();
    #1 chk("to_cleared", 32'(timeout_error), 32'd0);
    tick();
    reset = 0;
    tick();

    // Reset while a read is in flight and another read is pending.
    p0_req = 1; p0_we = 0; p0_addr = 18'h9; ctrl_main_state = 5'd11;
    tick(); tick();
    chk("mr_ack", 32'(p0_ack), 32'd1);
    ctrl_main_state = 5'd0;
    tick(); tick();
    chk("mr_pending_busy", 32'(busy), 32'd1);
    #2 reset = 1; model_reset();
    #1 chk("mr_outputs_zero", 32'({busy, ctrl_read_enable, ctrl_write_enable, p0_ack, p1_ack,
                                  p0_rvalid, p1_rvalid, timeout_error}), 32'd0);
    chk("mr_addr_zero", 32'(ctrl_address), 32'd0);
    p0_req = 0;
    tick();
    reset = 0; ctrl_main_state = 5'd11;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mr_no_rvalid", 32'(p0_rvalid), 32'd0);
      chk("mr_no_ack", 32'(p0_ack), 32'd0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 599) == 0) reset = 1;
      client(e_ack0, p0_req, p0_we, p0_addr, p0_wdata);
      client(e_ack1, p1_req, p1_we, p1_addr, p1_wdata);
      if (stuck > 0) begin
        ctrl_main_state = SW'($urandom_range(0, 7));
        stuck--;
      end else if ($urandom_range(0, 39) == 0) begin
        stuck = 10;
        ctrl_main_state = 5'd0;
      end else begin
        case ($urandom_range(0, 3))
          0: ctrl_main_state = 5'd8;
          1: ctrl_main_state = 5'd11;
          default: ctrl_main_state = SW'($urandom_range(0, 31));
        endcase
      end
      ctrl_data_from_ram = DW'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_user_port_arbiter.md
Name: ddr3_user_port_arbiter

Overview:
Two-requester arbiter that shares the single user interface of ddr3_memory_controller (write_enable, read_enable, i_user_data_address, data_to_ram, data_from_ram). It sits between two client blocks (e.g. loopback tester and a DMA port) and the controller. It grants one request at a time, round-robin, and holds the command until the controller accepts it. Read data is then routed back to the originating port after a fixed latency.

Parameters:
ADDR_BITWIDTH, 18, bank+row/col user address width (BANK_ADDRESS_BITWIDTH 3 + ADDRESS_BITWIDTH 15)
DQ_BITWIDTH, 16, user data width
STATE_BITWIDTH, 5, width of controller main_state
STATE_WRITE_DATA, 8, controller state value that accepts a write
STATE_READ_DATA, 11, controller state value that accepts a read
READ_LATENCY, 4, cycles from read acceptance to valid data_from_ram (>=1)
ACCEPT_TIMEOUT, 1023, max cycles a granted command may wait for acceptance

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
p0_req, p1_req  in  1 each  request, held high until pN_ack
p0_we, p1_we  in  1 each  1=write, 0=read
p0_addr, p1_addr  in  ADDR_BITWIDTH each  user address
p0_wdata, p1_wdata  in  DQ_BITWIDTH each  write data
p0_ack, p1_ack  out  1 each  one-cycle pulse: command accepted by controller
p0_rvalid, p1_rvalid  out  1 each  one-cycle pulse: read data valid on rdata
rdata  out  DQ_BITWIDTH  read data (shared by both ports)
ctrl_main_state  in  STATE_BITWIDTH  controller main_state
ctrl_write_enable  out  1  to controller write_enable
ctrl_read_enable  out  1  to controller read_enable
ctrl_address  out  ADDR_BITWIDTH  to i_user_data_address
ctrl_data_to_ram  out  DQ_BITWIDTH  to data_to_ram
ctrl_data_from_ram  in  DQ_BITWIDTH  from data_from_ram
busy  out  1  high while in GRANT
timeout_error  out  1  sticky: acceptance timeout occurred

Behaviour:
- Reset (async, any time): all outputs 0; FSM=IDLE; rr_pointer=0 (port 0 preferred); read-return pipeline flushed; timeout counter 0. Reads in flight at reset are discarded; no rvalid after reset.
- FSM states: IDLE, GRANT, DONE.
- IDLE: if any req -> latch the winner's we/addr/wdata into ctrl_* registers and record owner. Go to GRANT next cycle. Winner: the only requester; if both request, the port equal to rr_pointer. No req -> stay, enables 0.
- GRANT: ctrl_write_enable=we, ctrl_read_enable=~we (registered, stable), busy=1; counter increments each cycle.
  - Accept when (we && ctrl_main_state==STATE_WRITE_DATA) or (!we && ctrl_main_state==STATE_READ_DATA) -> next cycle: enables 0, owner ack pulses 1 cycle, rr_pointer=~owner, go DONE.
  - If the counter reaches ACCEPT_TIMEOUT without acceptance: set timeout_error, drop enables, do not ack, rr_pointer=~owner, go DONE. The request remains asserted and is re-arbitrated.
- DONE: one turnaround cycle, enables 0, then IDLE. Back-to-back commands from the same port are therefore spaced >=3 cycles apart. The minimum is IDLE->GRANT->(accept)->DONE.
- Client req/we/addr/wdata changes during GRANT are ignored (latched copy used). Client must deassert req in or after the ack cycle. A req still high in the cycle after ack is treated as a new request.
- Read return: on a read acceptance, push {1, owner} into a READ_LATENCY-deep shift register. At the tail entry, drive rdata<=ctrl_data_from_ram and pulse rvalid of the tagged owner for 1 cycle. Writes push {0, x}. Up to READ_LATENCY reads may be in flight; ordering is preserved.
- rdata holds its last value between rvalid pulses.
- timeout_error cleared only by reset.
- Simultaneous ack and rvalid to the same or different ports are legal and independent.

Test Plan:
- Reset mid-GRANT (p0 read pending, state != 11) -> all outputs 0 within same cycle, no later p0_ack/p0_rvalid.
- p0 write addr 0x00010 data 0x1234, state driven 8 two cycles after grant -> ctrl_write_enable=1, ctrl_address=0x00010, ctrl_data_to_ram=0x1234 until accept; p0_ack one pulse; enables 0 afterwards.
- p0 and p1 both request continuously (writes), state held at 8 -> grants alternate p0,p1,p0,p1; rr_pointer toggles; no port gets two consecutive acks.
- p1 read addr 0x3FFFF, accept at state 11, ctrl_data_from_ram=0xBEEF exactly READ_LATENCY cycles later -> p1_rvalid single pulse, rdata=0xBEEF, p0_rvalid stays 0.
- p0 read then p1 read accepted back-to-back, return data 0x0001 then 0x0002 -> p0_rvalid with 0x0001 first, p1_rvalid with 0x0002 next, order preserved.
- ACCEPT_TIMEOUT=7, state never reaches 8 for p0 write -> timeout_error=1 after 7 GRANT cycles, no p0_ack, p1 request (if present) granted next; timeout_error remains 1 until reset.
